vga_mem_arbiter: RTL
====================

Name: vga_mem_arbiter

Overview:
- Arbitrates the single-port frame memory among four requesters:
  - camera pixel writer (CAM)
  - HPS image readback (HPS)
  - line-buffer loader (BUF)
  - convolution/VGA result writer (CONV)
- Sits between those clients and the frame RAM. It replaces the ad-hoc address/data/write-enable muxing with one request/ack handshake per client.
- Tags each issued read and returns read data to the originating client with a valid strobe.
- Tracks starvation and exposes status to the control FSM.

Parameters:
- ADDR_W, 16, frame memory address width
- DATA_W, 32, frame memory word width
- RD_LAT, 1, RAM read latency in clk cycles (1..3)
- STARVE_LIMIT, 1023, max cycles a non-CAM request may wait before starve_err

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cam_req  in  1  CAM write request; already synchronized to clk
- cam_addr  in  ADDR_W  CAM write address
- cam_wdata  in  DATA_W  CAM write data
- cam_ack  out  1  CAM access issued this cycle
- hps_req  in  1  HPS read request
- hps_addr  in  ADDR_W  HPS read address
- hps_ack  out  1  HPS access issued this cycle
- hps_rvalid  out  1  rdata belongs to HPS this cycle
- buf_req  in  1  BUF read request
- buf_addr  in  ADDR_W  BUF read address
- buf_ack  out  1  BUF access issued this cycle
- buf_rvalid  out  1  rdata belongs to BUF this cycle
- conv_req  in  1  CONV write request
- conv_addr  in  ADDR_W  CONV write address
- conv_wdata  in  DATA_W  CONV write data
- conv_ack  out  1  CONV access issued this cycle
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after issue
- rdata  out  DATA_W  registered copy of mem_rdata, qualified by *_rvalid
- busy  out  1  any request pending or read in flight
- starve_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - all acks, rvalids, mem_we, starve_err = 0
  - mem_addr = 0, mem_wdata = 0, rdata = 0
  - round-robin pointer = HPS
  - tag pipeline cleared; wait counters = 0
- Reset asserted mid-read: the in-flight read is dropped and no rvalid is ever produced for it.
- Issue, combinational within the cycle:
  - At most one access per cycle.
  - CAM has absolute priority: cam_req=1 means cam_ack=1, mem_we=1, mem_addr=cam_addr, mem_wdata=cam_wdata.
  - Otherwise, round-robin among HPS -> BUF -> CONV, starting at the pointer. The first asserted requester gets its ack; mem_addr comes from that requester; mem_we=1 only for CONV.
  - With no grant: mem_we=0, and mem_addr/mem_wdata hold their previous value (registered shadow).
- Pointer update (at clk edge, only on a non-CAM grant): pointer moves to the requester after the granted one, wrapping CONV -> HPS. A CAM grant leaves the pointer unchanged.
- Handshake:
  - A requester holds req and its addr/wdata stable until it sees ack=1 in the same cycle.
  - If req stays high in the cycle after ack, that is a new access.
  - Ack is a per-cycle pulse; back-to-back grants to the same client are legal when no other non-CAM client is requesting.
- Read return:
  - A 2-bit tag (NONE/HPS/BUF) is shifted through an RD_LAT-deep pipeline at issue.
  - At the tail, mem_rdata is registered into rdata and the matching rvalid pulses for one cycle.
  - Read latency from ack to rvalid = RD_LAT+1 cycles.
  - Writes enter tag NONE; they never produce rvalid.
- Starvation:
  - Each non-CAM client has a wait counter that increments while req=1 and ack=0, and clears on ack or when req=0.
  - Counter reaching STARVE_LIMIT sets starve_err. The counter saturates and does not wrap.
- busy = any req asserted OR any non-NONE tag in the pipeline.
- Simultaneous events:
  - All four requesting: CAM wins; the others wait with the pointer frozen.
  - Once CAM drops, HPS, BUF and CONV are served in pointer order, one per cycle.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no reqs -> all outputs 0, busy=0; rst_n dropped asynchronously mid-cycle -> outputs clear before the next edge.
- Single HPS read, RD_LAT=1, hps_addr=16'h0123, RAM word 32'hDEADBEEF -> hps_ack in cycle 0, mem_we=0, mem_addr=16'h0123; hps_rvalid=1 and rdata=32'hDEADBEEF in cycle 2; buf_rvalid stays 0.
- HPS, BUF and CONV held high together for 6 cycles -> ack order HPS, BUF, CONV, HPS, BUF, CONV; mem_we=1 only in the CONV cycles, with mem_wdata=conv_wdata.
- CAM asserted for 4 cycles while BUF requests (pointer at BUF) -> cam_ack in cycles 0-3, buf_ack in cycle 4, pointer still BUF before cycle 4.
- STARVE_LIMIT=8, cam_req held high with conv_req high for 12 cycles -> starve_err rises after conv has waited 8 cycles, and stays 1 after CAM releases and conv_ack occurs.
- BUF read issued, rst_n pulsed low on the next cycle -> no buf_rvalid ever appears, and a post-reset BUF read returns correct data in 2 cycles.

Source files
------------

// File: rtl/vga_mem_arbiter_if.sv
// Client/RAM bundle for the frame-memory arbiter.
// The slave view is the arbiter; the master view is the clients plus the RAM.
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cam_req;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_wdata;
    logic              cam_ack;
    logic              hps_req;
    logic [ADDR_W-1:0] hps_addr;
    logic              hps_ack;
    logic              hps_rvalid;
    logic              buf_req;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_ack;
    logic              buf_rvalid;
    logic              conv_req;
    logic [ADDR_W-1:0] conv_addr;
    logic [DATA_W-1:0] conv_wdata;
    logic              conv_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              starve_err;

    modport slave (
        input  cam_req, cam_addr, cam_wdata, hps_req, hps_addr, buf_req, buf_addr,
               conv_req, conv_addr, conv_wdata, mem_rdata,
        output cam_ack, hps_ack, hps_rvalid, buf_ack, buf_rvalid, conv_ack,
               mem_addr, mem_wdata, mem_we, rdata, busy, starve_err
    );

    modport master (
        output cam_req, cam_addr, cam_wdata, hps_req, hps_addr, buf_req, buf_addr,
               conv_req, conv_addr, conv_wdata, mem_rdata,
        input  cam_ack, hps_ack, hps_rvalid, buf_ack, buf_rvalid, conv_ack,
               mem_addr, mem_wdata, mem_we, rdata, busy, starve_err
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Frame-memory arbiter: CAM strict priority, round-robin HPS/BUF/CONV,
// tagged read return and sticky starvation flag.
module vga_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_mem_arbiter_if.slave bus
);
    // state    | meaning
    // PTR_HPS  | HPS has first claim on the next non-CAM slot
    // PTR_BUF  | BUF has first claim on the next non-CAM slot
    // PTR_CONV | CONV has first claim on the next non-CAM slot
    typedef enum logic [1:0] {PTR_HPS = 2'd0, PTR_BUF = 2'd1, PTR_CONV = 2'd2} ptr_t;
    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_HPS = 2'd1, TAG_BUF = 2'd2} tag_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(STARVE_LIMIT);

    ptr_t              ptr_q, ptr_d;
    logic              gnt_cam, gnt_hps, gnt_buf, gnt_conv;
    logic [ADDR_W-1:0] addr_q, addr_c;
    logic [DATA_W-1:0] wdata_q, wdata_c, rdata_q;
    logic              we_c;
    tag_t              issue_tag;
    tag_t              tag_pipe [RD_LAT];
    tag_t              tag_tail;
    logic              pipe_busy;
    logic              hps_rvalid_q, buf_rvalid_q, starve_q;
    logic [CNT_W-1:0]  hps_wait_q, buf_wait_q, conv_wait_q;
    logic [CNT_W-1:0]  hps_wait_d, buf_wait_d, conv_wait_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= PTR_HPS;
        else        ptr_q <= ptr_d;
    end

    always_comb begin
        gnt_cam  = 1'b0;
        gnt_hps  = 1'b0;
        gnt_buf  = 1'b0;
        gnt_conv = 1'b0;
        ptr_d    = ptr_q;
        if (bus.cam_req) begin
            gnt_cam = 1'b1;
        end else begin
            case (ptr_q)
                PTR_HPS: begin
                    if      (bus.hps_req)  gnt_hps  = 1'b1;
                    else if (bus.buf_req)  gnt_buf  = 1'b1;
                    else if (bus.conv_req) gnt_conv = 1'b1;
                end
                PTR_BUF: begin
                    if      (bus.buf_req)  gnt_buf  = 1'b1;
                    else if (bus.conv_req) gnt_conv = 1'b1;
                    else if (bus.hps_req)  gnt_hps  = 1'b1;
                end
                default: begin
                    if      (bus.conv_req) gnt_conv = 1'b1;
                    else if (bus.hps_req)  gnt_hps  = 1'b1;
                    else if (bus.buf_req)  gnt_buf  = 1'b1;
                end
            endcase
            if      (gnt_hps)  ptr_d = PTR_BUF;
            else if (gnt_buf)  ptr_d = PTR_CONV;
            else if (gnt_conv) ptr_d = PTR_HPS;
        end
    end

    // Idle cycles replay the last issued address/data so the RAM pins stay quiet.
    always_comb begin
        addr_c    = addr_q;
        wdata_c   = wdata_q;
        we_c      = 1'b0;
        issue_tag = TAG_NONE;
        if (gnt_cam) begin
            addr_c  = bus.cam_addr;
            wdata_c = bus.cam_wdata;
            we_c    = 1'b1;
        end else if (gnt_hps) begin
            addr_c    = bus.hps_addr;
            issue_tag = TAG_HPS;
        end else if (gnt_buf) begin
            addr_c    = bus.buf_addr;
            issue_tag = TAG_BUF;
        end else if (gnt_conv) begin
            addr_c  = bus.conv_addr;
            wdata_c = bus.conv_wdata;
            we_c    = 1'b1;
        end
    end

    assign tag_tail = tag_pipe[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            hps_rvalid_q <= 1'b0;
            buf_rvalid_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            addr_q      <= addr_c;
            wdata_q     <= wdata_c;
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            hps_rvalid_q <= (tag_tail == TAG_HPS);
            buf_rvalid_q <= (tag_tail == TAG_BUF);
            if (tag_tail != TAG_NONE) rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++)
            if (tag_pipe[i] != TAG_NONE) pipe_busy = 1'b1;
    end

    function automatic logic [CNT_W-1:0] wait_next(input logic req, input logic ack,
                                                   input logic [CNT_W-1:0] cnt);
        if (!req || ack)     return '0;
        if (cnt == WAIT_MAX) return cnt;
        return cnt + 1'b1;
    endfunction

    assign hps_wait_d  = wait_next(bus.hps_req,  gnt_hps,  hps_wait_q);
    assign buf_wait_d  = wait_next(bus.buf_req,  gnt_buf,  buf_wait_q);
    assign conv_wait_d = wait_next(bus.conv_req, gnt_conv, conv_wait_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hps_wait_q  <= '0;
            buf_wait_q  <= '0;
            conv_wait_q <= '0;
            starve_q    <= 1'b0;
        end else begin
            hps_wait_q  <= hps_wait_d;
            buf_wait_q  <= buf_wait_d;
            conv_wait_q <= conv_wait_d;
            if (hps_wait_d == WAIT_MAX || buf_wait_d == WAIT_MAX || conv_wait_d == WAIT_MAX)
                starve_q <= 1'b1;
        end
    end

    assign bus.cam_ack    = gnt_cam;
    assign bus.hps_ack    = gnt_hps;
    assign bus.buf_ack    = gnt_buf;
    assign bus.conv_ack   = gnt_conv;
    assign bus.mem_addr   = addr_c;
    assign bus.mem_wdata  = wdata_c;
    assign bus.mem_we     = we_c;
    assign bus.rdata      = rdata_q;
    assign bus.hps_rvalid = hps_rvalid_q;
    assign bus.buf_rvalid = buf_rvalid_q;
    assign bus.starve_err = starve_q;
    assign bus.busy       = bus.cam_req | bus.hps_req | bus.buf_req | bus.conv_req | pipe_busy;
endmodule
